// File: rtl/spi_pkg.sv
// Shared constants, state encoding and bit-order helper for the SPI responder.
package spi_pkg;

    localparam int unsigned SPI_BITS_FAST = 32;
    localparam int unsigned SPI_BITS_SLOW = 8;

    // Shifted out when the CPU has not supplied a transmit word.
    localparam logic [31:0] SPI_IDLE_FILL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } spi_state_e;

    // Serial bit k maps to word bit: byte k/8, MSbit first within the byte.
    // Slow frames only use k < 8, which reduces to plain 7..0 order.
    function automatic logic [4:0] spi_bit_index(input logic [4:0] cnt);
        return {cnt[4:3], ~cnt[2:0]};
    endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// CPU-side register handshake of the SPI responder.
interface spi_peripheral_if;

    logic        fast;
    logic [31:0] dataTx;
    logic        txLoad;
    logic        txEmpty;
    logic [31:0] dataRx;
    logic        rxRdy;
    logic        rxAck;
    logic        overrun;

    modport master (
        output fast, dataTx, txLoad, rxAck,
        input  txEmpty, dataRx, rxRdy, overrun
    );

    modport slave (
        input  fast, dataTx, txLoad, rxAck,
        output txEmpty, dataRx, rxRdy, overrun
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous pin, with selectable reset value.
module sync2 #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversampled pins, 8-bit or 32-bit frames, word handshake to the CPU.
module spi_peripheral
    import spi_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    spi_peripheral_if.slave bus,
    input  logic            SS,
    input  logic            SCLK,
    input  logic            MOSI,
    output logic            MISO,
    output logic            misoOe
);

    logic        ss_s, sclk_s, mosi_s;
    logic        ss_prev_q, sclk_prev_q;
    logic [1:0]  fill_q;
    logic        armed_q;
    spi_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d, out_cnt_q, out_cnt_d, last_bit;
    logic [31:0] tx_q, tx_d, hold_q, hold_d, rx_q, rx_d, data_rx_q, data_rx_d, rx_word;
    logic        tx_empty_q, tx_empty_d, rx_rdy_q, rx_rdy_d, overrun_q, overrun_d;
    logic        consume, complete;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

    sync2 #(.ResetVal(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .d(SS),   .q(ss_s));
    sync2 #(.ResetVal(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(SCLK), .q(sclk_s));
    sync2 #(.ResetVal(1'b1)) u_sync_mosi (.clk(clk), .rst(rst), .d(MOSI), .q(mosi_s));

    // A falling SS only counts once SS has really been seen high after reset.
    assign ss_fall   = armed_q & ss_prev_q & ~ss_s;
    assign ss_rise   = ~ss_prev_q & ss_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign last_bit  = bus.fast ? 5'(SPI_BITS_FAST - 1) : 5'(SPI_BITS_SLOW - 1);

    // Edge-detect history and arming once the synchroniser shows a genuine SS high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            fill_q      <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            ss_prev_q   <= ss_s;
            sclk_prev_q <= sclk_s;
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd2 && ss_s) armed_q <= 1'b1;
        end
    end

    // Frame state, shift registers and CPU-visible flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            out_cnt_q  <= '0;
            tx_q       <= SPI_IDLE_FILL;
            hold_q     <= '0;
            tx_empty_q <= 1'b1;
            rx_q       <= '0;
            data_rx_q  <= '0;
            rx_rdy_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
            tx_q       <= tx_d;
            hold_q     <= hold_d;
            tx_empty_q <= tx_empty_d;
            rx_q       <= rx_d;
            data_rx_q  <= data_rx_d;
            rx_rdy_q   <= rx_rdy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state: frame sequencing, bit capture, holding-register and flag handshakes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_cnt_d  = out_cnt_q;
        tx_d       = tx_q;
        hold_d     = hold_q;
        tx_empty_d = tx_empty_q;
        rx_d       = rx_q;
        data_rx_d  = data_rx_q;
        rx_rdy_d   = rx_rdy_q;
        overrun_d  = overrun_q;
        consume    = 1'b0;
        complete   = 1'b0;
        rx_word    = rx_q;
        rx_word[spi_bit_index(cnt_q)] = mosi_s;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) state_d = StLoad;
            end
            StLoad: begin
                consume   = 1'b1;
                cnt_d     = '0;
                out_cnt_d = '0;
                rx_d      = '0;
                state_d   = ss_rise ? StIdle : StShift;
            end
            StShift: begin
                if (ss_rise) begin
                    // Abort: partial frame is dropped.
                    state_d   = StIdle;
                    cnt_d     = '0;
                    out_cnt_d = '0;
                end else if (sclk_rise) begin
                    if (cnt_q == last_bit) begin
                        // Reload at once so another frame can follow under the same SS.
                        complete  = 1'b1;
                        consume   = 1'b1;
                        cnt_d     = '0;
                        out_cnt_d = '0;
                        rx_d      = '0;
                    end else begin
                        rx_d  = rx_word;
                        cnt_d = cnt_q + 5'd1;
                    end
                end else if (sclk_fall) begin
                    out_cnt_d = cnt_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (consume) begin
            tx_d       = tx_empty_q ? SPI_IDLE_FILL : hold_q;
            tx_empty_d = 1'b1;
        end
        // A CPU write beats a same-cycle consumption.
        if (bus.txLoad) begin
            hold_d     = bus.dataTx;
            tx_empty_d = 1'b0;
        end

        // A completion beats a same-cycle acknowledge.
        if (complete) begin
            data_rx_d = bus.fast ? rx_word : {24'b0, rx_word[7:0]};
            rx_rdy_d  = 1'b1;
            overrun_d = bus.rxAck ? 1'b0 : (overrun_q | rx_rdy_q);
        end else if (bus.rxAck) begin
            rx_rdy_d  = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign MISO        = (state_q == StShift) ? tx_q[spi_bit_index(out_cnt_q)] : 1'b1;
    assign misoOe      = (state_q != StIdle);
    assign bus.txEmpty = tx_empty_q;
    assign bus.dataRx  = data_rx_q;
    assign bus.rxRdy   = rx_rdy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: fixed vectors, corner sequences, random frames.
module tb_spi_peripheral;

    localparam int H = 8;  // clk cycles per SCLK half period

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic SS = 1'b1, SCLK = 1'b0, MOSI = 1'b1;
    logic MISO, misoOe;

    spi_peripheral_if bus ();

    spi_peripheral dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .SS    (SS),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .misoOe(misoOe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          fast;
        bit          load;
        logic [31:0] tx;
        logic [31:0] mosi;
        logic [31:0] exp_miso;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs [4];

    // Reference model of the CPU-visible state.
    logic [31:0] m_hold, m_data;
    bit          m_empty, m_rdy, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Position in the word of the k-th serial bit: bytes low to high, MSbit first.
    function automatic int serial_pos(input int k);
        return (k / 8) * 8 + (7 - (k % 8));
    endfunction

    task automatic cpu_load(input logic [31:0] d);
        bus.dataTx = d;
        bus.txLoad = 1'b1;
        tick();
        bus.txLoad = 1'b0;
    endtask

    task automatic cpu_ack();
        bus.rxAck = 1'b1;
        tick();
        bus.rxAck = 1'b0;
    endtask

    // Drop SS; optionally strobe txLoad in the LOAD cycle (3 clk after the pin falls).
    task automatic ss_begin(input bit load_in_load, input logic [31:0] d);
        SS = 1'b0;
        repeat (3) tick();
        if (load_in_load) begin
            bus.dataTx = d;
            bus.txLoad = 1'b1;
        end
        tick();
        bus.txLoad = 1'b0;
    endtask

    task automatic ss_end();
        repeat (H) tick();
        SS = 1'b1;
        repeat (6) tick();
    endtask

    // Master side of one frame (or a partial one); samples MISO at each rise.
    task automatic xfer(input bit f, input int nbits, input logic [31:0] mosi_w, input bit ack_done,
                        output logic [31:0] miso_w, output logic rdy2, output logic rdy3);
        miso_w = '0;
        rdy2   = 1'b0;
        rdy3   = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            MOSI = mosi_w[serial_pos(k)];
            repeat (H) tick();
            miso_w[serial_pos(k)] = MISO;
            SCLK = 1'b1;
            if (k == nbits - 1) begin
                repeat (2) tick();
                rdy2 = bus.rxRdy;
                if (ack_done) bus.rxAck = 1'b1;
                tick();
                bus.rxAck = 1'b0;
                rdy3 = bus.rxRdy;
                repeat (H - 3) tick();
            end else begin
                repeat (H) tick();
            end
            SCLK = 1'b0;
        end
        if (f) miso_w = miso_w;
    endtask

    initial begin
        logic [31:0] mw, mw2, d, exp_tx, rxw;
        logic        r2, r3;
        bit          f;

        vecs[0] = '{fast: 1'b0, load: 1'b1, tx: 32'h0000_00A5, mosi: 32'h0000_003C,
                    exp_miso: 32'h0000_00A5, exp_rx: 32'h0000_003C};
        vecs[1] = '{fast: 1'b1, load: 1'b1, tx: 32'h1122_3344, mosi: 32'h5566_7788,
                    exp_miso: 32'h1122_3344, exp_rx: 32'h5566_7788};
        vecs[2] = '{fast: 1'b0, load: 1'b0, tx: 32'h0, mosi: 32'h0000_005A,
                    exp_miso: 32'h0000_00FF, exp_rx: 32'h0000_005A};
        vecs[3] = '{fast: 1'b1, load: 1'b0, tx: 32'h0, mosi: 32'hDEAD_BEEF,
                    exp_miso: 32'hFFFF_FFFF, exp_rx: 32'hDEAD_BEEF};

        bus.fast   = 1'b0;
        bus.dataTx = '0;
        bus.txLoad = 1'b0;
        bus.rxAck  = 1'b0;
        repeat (3) tick();

        check("rst_miso",    32'(MISO),        32'd1);
        check("rst_misooe",  32'(misoOe),      32'd0);
        check("rst_datarx",  bus.dataRx,       32'd0);
        check("rst_rxrdy",   32'(bus.rxRdy),   32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_txempty", 32'(bus.txEmpty), 32'd1);
        rst = 1'b1;
        repeat (4) tick();

        // Table vectors: one frame per SS period.
        for (int i = 0; i < 4; i++) begin
            bus.fast = vecs[i].fast;
            tick();
            if (vecs[i].load) cpu_load(vecs[i].tx);
            ss_begin(1'b0, 32'h0);
            check($sformatf("v%0d_misooe", i), 32'(misoOe), 32'd1);
            check($sformatf("v%0d_first_bit", i), 32'(MISO), 32'(vecs[i].exp_miso[7]));
            xfer(vecs[i].fast, vecs[i].fast ? 32 : 8, vecs[i].mosi, 1'b0, mw, r2, r3);
            ss_end();
            check($sformatf("v%0d_miso", i), mw, vecs[i].exp_miso);
            check($sformatf("v%0d_datarx", i), bus.dataRx, vecs[i].exp_rx);
            check($sformatf("v%0d_rdy_early", i), 32'(r2), 32'd0);
            check($sformatf("v%0d_rdy_at3", i), 32'(r3), 32'd1);
            check($sformatf("v%0d_overrun", i), 32'(bus.overrun), 32'd0);
            check($sformatf("v%0d_txempty", i), 32'(bus.txEmpty), 32'd1);
            check($sformatf("v%0d_misooe_idle", i), 32'(misoOe), 32'd0);
            cpu_ack();
        end

        // Abort after 5 of 8 bits, then a clean frame.
        bus.fast = 1'b0;
        tick();
        ss_begin(1'b0, 32'h0);
        xfer(1'b0, 5, 32'h0000_00C6, 1'b0, mw, r2, r3);
        ss_end();
        check("abort_rxrdy",  32'(bus.rxRdy), 32'd0);
        check("abort_datarx", bus.dataRx, 32'hDEAD_BEEF);
        ss_begin(1'b0, 32'h0);
        xfer(1'b0, 8, 32'h0000_0096, 1'b0, mw, r2, r3);
        ss_end();
        check("after_abort_datarx", bus.dataRx, 32'h0000_0096);
        check("after_abort_rxrdy",  32'(bus.rxRdy), 32'd1);
        cpu_ack();

        // Empty transmit, two back-to-back frames, no acknowledge.
        ss_begin(1'b0, 32'h0);
        xfer(1'b0, 8, 32'h0000_0021, 1'b0, mw, r2, r3);
        xfer(1'b0, 8, 32'h0000_0084, 1'b0, mw2, r2, r3);
        ss_end();
        check("ovr_miso1",   mw,  32'h0000_00FF);
        check("ovr_miso2",   mw2, 32'h0000_00FF);
        check("ovr_flag",    32'(bus.overrun), 32'd1);
        check("ovr_rxrdy",   32'(bus.rxRdy), 32'd1);
        check("ovr_datarx",  bus.dataRx, 32'h0000_0084);
        cpu_ack();
        check("ack_rxrdy",   32'(bus.rxRdy), 32'd0);
        check("ack_overrun", 32'(bus.overrun), 32'd0);

        // Collisions: leave a frame pending, load in LOAD cycle, ack in completion cycle.
        ss_begin(1'b0, 32'h0);
        xfer(1'b0, 8, 32'h0000_0011, 1'b0, mw, r2, r3);
        ss_end();
        ss_begin(1'b1, 32'h0000_00C3);
        check("col_txempty", 32'(bus.txEmpty), 32'd0);
        xfer(1'b0, 8, 32'h0000_007E, 1'b1, mw, r2, r3);
        check("col_rdy_kept",  32'(r3), 32'd1);
        check("col_overrun",   32'(bus.overrun), 32'd0);
        check("col_datarx",    bus.dataRx, 32'h0000_007E);
        check("col_miso_fill", mw, 32'h0000_00FF);
        xfer(1'b0, 8, 32'h0000_0042, 1'b0, mw2, r2, r3);
        ss_end();
        check("col_miso_new",  mw2, 32'h0000_00C3);
        check("col_txempty2",  32'(bus.txEmpty), 32'd1);
        check("col_overrun2",  32'(bus.overrun), 32'd1);
        cpu_ack();

        // Asynchronous reset in the middle of a fast frame.
        bus.fast = 1'b1;
        tick();
        cpu_load(32'hCAFE_F00D);
        ss_begin(1'b0, 32'h0);
        xfer(1'b1, 12, 32'h1234_5678, 1'b0, mw, r2, r3);
        rst = 1'b0;
        #1;
        check("arst_miso",    32'(MISO),        32'd1);
        check("arst_misooe",  32'(misoOe),      32'd0);
        check("arst_datarx",  bus.dataRx,       32'd0);
        check("arst_rxrdy",   32'(bus.rxRdy),   32'd0);
        check("arst_overrun", 32'(bus.overrun), 32'd0);
        check("arst_txempty", 32'(bus.txEmpty), 32'd1);
        #5;
        rst = 1'b1;
        repeat (10) tick();
        check("arst_ss_ignored", 32'(misoOe), 32'd0);
        SS = 1'b1;
        repeat (6) tick();
        cpu_load(32'h0BAD_BEEF);
        ss_begin(1'b0, 32'h0);
        xfer(1'b1, 32, 32'hA1B2_C3D4, 1'b0, mw, r2, r3);
        ss_end();
        check("arst_new_miso",   mw, 32'h0BAD_BEEF);
        check("arst_new_datarx", bus.dataRx, 32'hA1B2_C3D4);
        check("arst_new_rxrdy",  32'(bus.rxRdy), 32'd1);
        cpu_ack();

        // Random frames against the reference model.
        m_hold  = 32'h0BAD_BEEF;
        m_empty = 1'b1;
        m_rdy   = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 32'hA1B2_C3D4;
        for (int i = 0; i < 20; i++) begin
            f = 1'($urandom_range(0, 1));
            bus.fast = f;
            tick();
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                cpu_load(d);
                m_hold  = d;
                m_empty = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                cpu_ack();
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            mw = $urandom;
            exp_tx  = m_empty ? 32'hFFFF_FFFF : m_hold;
            m_empty = 1'b1;
            ss_begin(1'b0, 32'h0);
            xfer(f, f ? 32 : 8, mw, 1'b0, mw2, r2, r3);
            ss_end();
            // Serial bytes b0..b3 land as {b3,b2,b1,b0}; slow keeps only b0.
            rxw = f ? {mw[31:24], mw[23:16], mw[15:8], mw[7:0]} : {24'b0, mw[7:0]};
            if (m_rdy) m_ovr = 1'b1;
            m_rdy  = 1'b1;
            m_data = rxw;
            check($sformatf("rnd%0d_miso", i), mw2, f ? exp_tx : {24'b0, exp_tx[7:0]});
            check($sformatf("rnd%0d_datarx", i), bus.dataRx, m_data);
            check($sformatf("rnd%0d_rxrdy", i), 32'(bus.rxRdy), 32'(m_rdy));
            check($sformatf("rnd%0d_overrun", i), 32'(bus.overrun), 32'(m_ovr));
            check($sformatf("rnd%0d_txempty", i), 32'(bus.txEmpty), 32'(m_empty));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI responder (slave) for the RISC5 peripheral bus, the opposite end of the system's SPI initiator. It lets the FPGA act as an SPI target for an external master such as a host MCU or a second Pepino board. It supports the same two framings as the initiator: 32-bit words, LSByte first and MSbit first within each byte (fast), or single bytes, MSbit first (slow). It runs in SPI mode 0, oversamples SCLK/MOSI/SS in the local `clk` domain, and presents word-level handshakes to the CPU-side register interface.

## Interface
- No parameters; widths are fixed (32-bit data, 5-bit bit counter).
- `clk`  in  1  system clock, 37.5 MHz nominal
- `rst`  in  1  asynchronous, active-low reset
- `fast`  in  1  1 = 32-bit word frames, 0 = 8-bit byte frames; changed only while SS is high
- `dataTx`  in  32  next transmit word (byte mode uses [7:0])
- `txLoad`  in  1  one-cycle strobe; writes `dataTx` into the holding register
- `txEmpty`  out  1  holding register has been consumed or was never loaded
- `dataRx`  out  32  last complete received frame (byte mode: {24'b0, byte})
- `rxRdy`  out  1  `dataRx` holds an unread frame
- `rxAck`  in  1  one-cycle strobe; clears `rxRdy` and `overrun`
- `overrun`  out  1  sticky; a frame completed while `rxRdy` was already 1
- `SS`  in  1  chip select, active low, asynchronous to `clk`
- `SCLK`  in  1  serial clock, asynchronous, CPOL = 0
- `MOSI`  in  1  serial data in, asynchronous
- `MISO`  out  1  serial data out
- `misoOe`  out  1  pad output enable for MISO, 1 only while SS is synchronised low

## Operation
- SS, SCLK and MOSI each pass through a 2-FF synchroniser. Edges are detected by comparing the synchronised value with a one-cycle-delayed copy.
- States:
  - IDLE (SS high).
  - LOAD: one cycle after the SS falling edge. The shift register takes the holding register if `txEmpty` = 0, otherwise all ones. `txEmpty` is set to 1 at the same time.
  - SHIFT.
- In SHIFT:
  - On a synchronised SCLK rise, capture synchronised MOSI.
  - On a synchronised SCLK fall, advance the output bit.
- Bit order (fast):
  - Transmit order is bits 7..0, 15..8, 23..16, 31..24.
  - The first received bit lands in dataRx[7]; the 32nd lands in dataRx[24].
  - Slow mode uses the plain [7:0] MSbit-first order.
- Frame completion is the rise of bit 7 (slow) or bit 31 (fast). On completion:
  - `dataRx` is written; incomplete frames are never written to `dataRx`.
  - `rxRdy` is set to 1. If `rxRdy` was already 1, `overrun` is set and `dataRx` is still overwritten.
  - The bit counter is reset to 0.
  - The shift register reloads from the holding register (or all ones), as in LOAD, so back-to-back frames can run within one SS-low period.
- SS rise in mid-frame aborts the frame: the partial frame is discarded, the bit counter is reset to 0, and there is no `rxRdy` or `overrun`. The holding register is unaffected unless it was consumed at LOAD.
- MISO is 1 whenever not in SHIFT or LOAD. `misoOe` = (state != IDLE).
- `txLoad` in the same cycle as a consumption: the load wins, and `txEmpty` ends at 0 holding the new word. `rxAck` in the same cycle as a completion: the completion wins, so `rxRdy` stays 1 and `overrun` is not set by that completion.

## Timing
- Reset values: `MISO` 1, `misoOe` 0, `dataRx` 0, `rxRdy` 0, `overrun` 0, `txEmpty` 1, state IDLE, bit counter 0, synchroniser FFs to 1/0/1 (SS/SCLK/MOSI).
- Edge latency: a pin edge at clk cycle t is detected at t+2, and the registered effect is visible at t+3.
- MISO first bit is valid 4 clk after the SS pin falls. The master must wait at least 5 clk before the first SCLK rise.
- MISO advances 3 clk after the SCLK pin falls. The SCLK high and low phases must each be at least 4 clk periods.
- `rxRdy` rises 3 clk after the SCLK rise of the last bit.
- Reset asserted mid-frame returns everything to the reset values immediately (asynchronously). Pins are ignored until SS is seen high and then low again.

## Structure
- Shared package `spi_pkg`:
  - frame lengths (`SPI_BITS_FAST` = 32, `SPI_BITS_SLOW` = 8)
  - the state encoding (IDLE / LOAD / SHIFT)
  - the all-ones idle fill constant
- Sub-module `sync2` (2-FF synchroniser with reset value parameter), instantiated three times.

## Test plan
- Slow byte:
  - Stimulus: `txLoad` 0xA5, then the master sends 0x3C at 8 clk per half period.
  - Required: MISO carries 1,0,1,0,0,1,0,1; `dataRx` = 0x0000003C; `rxRdy` = 1 three cycles after the 8th rise; `txEmpty` = 1.
- Fast word:
  - Stimulus: `txLoad` 0x11223344, then the master sends bytes 0x88, 0x77, 0x66, 0x55.
  - Required: MISO byte order 0x44, 0x33, 0x22, 0x11; `dataRx` = 0x55667788.
- Empty transmit and overrun:
  - Stimulus: no `txLoad`, two back-to-back slow frames, no `rxAck`.
  - Required: MISO all ones; `overrun` = 1; `dataRx` = second byte; `rxAck` clears both flags.
- Abort:
  - Stimulus: SS rises after 5 of 8 bits.
  - Required: `rxRdy` stays 0, `dataRx` is unchanged, and the next full frame is received correctly.
- Collisions:
  - Stimulus: `txLoad` in the LOAD cycle; `rxAck` in the completion cycle.
  - Required: `txEmpty` = 0 holding the new word; `rxRdy` = 1 and `overrun` = 0.
- Async reset mid-word:
  - Stimulus: `rst` low for 1 cycle during a fast frame.
  - Required: all outputs return to their reset values at once, and a new SS frame works normally.
